// File: rtl/max_tracker_pipe.sv
// Pipelined running-maximum tracker: reduces NUM_LANES masked scores per beat through a
// registered RADIX-ary comparator tree, then folds the winner into a framed running max.
module max_tracker_pipe #(
  parameter int NUM_LANES      = 64,
  parameter int RADIX          = 4,
  parameter int SCORE_WIDTH    = 16,
  parameter int ROW_BITS_WIDTH = 10,
  parameter int COL_BITS_WIDTH = 10,
  parameter int UPD_CNT_WIDTH  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 valid_in,
  input  logic                                 last_in,
  input  logic [NUM_LANES-1:0]                 lane_mask,
  input  logic [NUM_LANES*SCORE_WIDTH-1:0]     score_in,
  input  logic [NUM_LANES*ROW_BITS_WIDTH-1:0]  row_in,
  input  logic [NUM_LANES*COL_BITS_WIDTH-1:0]  col_in,
  output logic [SCORE_WIDTH-1:0]               max_score,
  output logic [ROW_BITS_WIDTH-1:0]            max_row,
  output logic [COL_BITS_WIDTH-1:0]            max_col,
  output logic [UPD_CNT_WIDTH-1:0]             upd_cnt,
  output logic                                 result_valid,
  output logic                                 busy
);

  function automatic int calc_levels(input int n, input int r);
    int lv = 0;
    int span = 1;
    while (span < n) begin
      span = span * r;
      lv++;
    end
    return lv;
  endfunction

  function automatic int calc_nodes(input int pad, input int r);
    int total = 0;
    int w = pad / r;
    while (w >= 1) begin
      total += w;
      w = w / r;
    end
    return total;
  endfunction

  localparam int LEVELS = calc_levels(NUM_LANES, RADIX);
  localparam int PAD    = RADIX ** LEVELS;
  localparam int NODES  = calc_nodes(PAD, RADIX);
  // Heap-style layout: lanes occupy src[0..PAD-1], node t sits at src[PAD+t], and the
  // children of node t are src[t*RADIX .. t*RADIX+RADIX-1]. The root is never a child.
  localparam int SRC    = PAD + NODES - 1;

  logic [SCORE_WIDTH-1:0]    lane_sc  [PAD];
  logic [ROW_BITS_WIDTH-1:0] lane_row [PAD];
  logic [COL_BITS_WIDTH-1:0] lane_col [PAD];

  logic [SCORE_WIDTH-1:0]    src_sc  [SRC];
  logic [ROW_BITS_WIDTH-1:0] src_row [SRC];
  logic [COL_BITS_WIDTH-1:0] src_col [SRC];

  logic [SCORE_WIDTH-1:0]    node_sc  [NODES];
  logic [ROW_BITS_WIDTH-1:0] node_row [NODES];
  logic [COL_BITS_WIDTH-1:0] node_col [NODES];
  logic [SCORE_WIDTH-1:0]    nxt_sc   [NODES];
  logic [ROW_BITS_WIDTH-1:0] nxt_row  [NODES];
  logic [COL_BITS_WIDTH-1:0] nxt_col  [NODES];

  logic [LEVELS-1:0] stg_vld;
  logic [LEVELS-1:0] stg_lst;

  logic                      top_vld;
  logic                      top_lst;
  logic [SCORE_WIDTH-1:0]    top_sc;
  logic [ROW_BITS_WIDTH-1:0] top_row;
  logic [COL_BITS_WIDTH-1:0] top_col;

  // Masked and padding lanes enter the tree with score 0, which can never win an update.
  for (genvar i = 0; i < PAD; i++) begin : g_lane
    if (i < NUM_LANES) begin : g_real
      assign lane_sc[i]  = lane_mask[i] ? score_in[i*SCORE_WIDTH +: SCORE_WIDTH] : '0;
      assign lane_row[i] = row_in[i*ROW_BITS_WIDTH +: ROW_BITS_WIDTH];
      assign lane_col[i] = col_in[i*COL_BITS_WIDTH +: COL_BITS_WIDTH];
    end else begin : g_pad
      assign lane_sc[i]  = '0;
      assign lane_row[i] = '0;
      assign lane_col[i] = '0;
    end
  end

  // Strict greater-than while scanning children in order keeps the lowest index on ties.
  always_comb begin
    for (int i = 0; i < PAD; i++) begin
      src_sc[i]  = lane_sc[i];
      src_row[i] = lane_row[i];
      src_col[i] = lane_col[i];
    end
    for (int t = 0; t < NODES - 1; t++) begin
      src_sc[PAD+t]  = node_sc[t];
      src_row[PAD+t] = node_row[t];
      src_col[PAD+t] = node_col[t];
    end
    for (int t = 0; t < NODES; t++) begin
      nxt_sc[t]  = src_sc[t*RADIX];
      nxt_row[t] = src_row[t*RADIX];
      nxt_col[t] = src_col[t*RADIX];
      for (int j = 1; j < RADIX; j++) begin
        if (src_sc[t*RADIX+j] > nxt_sc[t]) begin
          nxt_sc[t]  = src_sc[t*RADIX+j];
          nxt_row[t] = src_row[t*RADIX+j];
          nxt_col[t] = src_col[t*RADIX+j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NODES; t++) begin
        node_sc[t]  <= '0;
        node_row[t] <= '0;
        node_col[t] <= '0;
      end
      stg_vld <= '0;
      stg_lst <= '0;
    end else begin
      for (int t = 0; t < NODES; t++) begin
        node_sc[t]  <= nxt_sc[t];
        node_row[t] <= nxt_row[t];
        node_col[t] <= nxt_col[t];
      end
      // A beat arriving with start is kept; everything older is flushed.
      stg_vld[0] <= valid_in;
      stg_lst[0] <= valid_in & last_in;
      for (int k = 1; k < LEVELS; k++) begin
        stg_vld[k] <= ~start & stg_vld[k-1];
        stg_lst[k] <= ~start & stg_lst[k-1];
      end
    end
  end

  assign top_vld = stg_vld[LEVELS-1];
  assign top_lst = stg_lst[LEVELS-1];
  assign top_sc  = node_sc[NODES-1];
  assign top_row = node_row[NODES-1];
  assign top_col = node_col[NODES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_score    <= '0;
      max_row      <= '0;
      max_col      <= '0;
      upd_cnt      <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (start) begin
      max_score    <= '0;
      max_row      <= '0;
      max_col      <= '0;
      upd_cnt      <= '0;
      result_valid <= 1'b0;
      busy         <= valid_in;
    end else begin
      result_valid <= top_vld & top_lst;
      if (top_vld && (top_sc > max_score)) begin
        max_score <= top_sc;
        max_row   <= top_row;
        max_col   <= top_col;
        if (upd_cnt != {UPD_CNT_WIDTH{1'b1}}) begin
          upd_cnt <= upd_cnt + UPD_CNT_WIDTH'(1);
        end
      end
      if (valid_in) begin
        busy <= 1'b1;
      end else if (top_vld && top_lst) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
